// File: rtl/chess_pkg.sv
// Shared types and constants for the board-selection controller.
//   SQ_W       square code width, {row[2:0],col[2:0]}
//   NUM_SLOTS  pieces per colour; slot s lives at lv[6s+5:6s], alive bit av[s]
//   state_t    selection sequencer states
//   piece_t    piece type implied by a slot index
package chess_pkg;

  localparam int unsigned SQ_W      = 6;
  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned LV_W      = NUM_SLOTS * SQ_W;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SELECTED,
    ARMED,
    MOVE_REQ
  } state_t;

  typedef enum logic [2:0] {
    KING,
    QUEEN,
    BISHOP,
    KNIGHT,
    ROOK,
    PAWN
  } piece_t;

  localparam logic [SLOT_W-1:0] SLOT_KING   = 4'd0;
  localparam logic [SLOT_W-1:0] SLOT_QUEEN  = 4'd1;
  localparam logic [SLOT_W-1:0] SLOT_BISHOP = 4'd2;
  localparam logic [SLOT_W-1:0] SLOT_KNIGHT = 4'd4;
  localparam logic [SLOT_W-1:0] SLOT_ROOK   = 4'd6;
  localparam logic [SLOT_W-1:0] SLOT_PAWN   = 4'd8;

  // Slot index -> piece type (slots are allocated in ascending type order).
  function automatic piece_t slot_piece(input logic [SLOT_W-1:0] slot);
    if (slot >= SLOT_PAWN)        return PAWN;
    else if (slot >= SLOT_ROOK)   return ROOK;
    else if (slot >= SLOT_KNIGHT) return KNIGHT;
    else if (slot >= SLOT_BISHOP) return BISHOP;
    else if (slot >= SLOT_QUEEN)  return QUEEN;
    else                          return KING;
  endfunction

endpackage

// File: rtl/chess_select_ctrl_if.sv
// Move request handshake between the selection controller and the move engine.
//   move_valid  request pending (held until move_ready is sampled)
//   move_ready  engine accepts the request
//   move_src    source square of the move
//   move_dst    destination square of the move
interface chess_select_ctrl_if;
  import chess_pkg::*;

  logic            move_valid;
  logic            move_ready;
  logic [SQ_W-1:0] move_src;
  logic [SQ_W-1:0] move_dst;

  modport master (output move_valid, output move_src, output move_dst, input move_ready);
  modport slave  (input move_valid, input move_src, input move_dst, output move_ready);
endinterface

// File: rtl/chess_select_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level.
//   clk, rst_n  clock and async active-low reset
//   level       debounced button level
//   rise_c      one-cycle pulse: level high now, low last cycle
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise_c
);

  logic prev;

  // History register for the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise_c = level & ~prev;

endmodule

// File: rtl/chess_select_ctrl.sv
// Board interaction sequencer: latches the piece under the cursor with a
// one-slot-per-cycle scan (white slots 0-15, then black 16-31), latches the
// destination, then issues one move request to the engine.
//   clk12, reset_n          clock, async active-low reset
//   cursor                  square under cursor
//   enter/esc/confirm_pressed  debounced button levels (rising edge used)
//   lvw, lvb, avw, avb      piece locations and alive bits per colour
//   player_in               side to move (1=white); used only with TURN_CHECK_EN
//   pid, pcolor, found_piece, dst_armed, busy  selection status to renderer
//   mv                      move request handshake (master side)
// Build option: TURN_CHECK_EN restricts matches to the side to move.
module chess_select_ctrl
  import chess_pkg::*;
(
  input  logic              clk12,
  input  logic              reset_n,
  input  logic [SQ_W-1:0]   cursor,
  input  logic              enter_pressed,
  input  logic              esc_pressed,
  input  logic              confirm_pressed,
  input  logic [LV_W-1:0]   lvw,
  input  logic [LV_W-1:0]   lvb,
  input  logic [NUM_SLOTS-1:0] avw,
  input  logic [NUM_SLOTS-1:0] avb,
  input  logic              player_in,
  output logic [SLOT_W-1:0] pid,
  output logic              pcolor,
  output logic              found_piece,
  output logic              dst_armed,
  output logic              busy,
  chess_select_ctrl_if.master mv
);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [SQ_W-1:0]   src, src_nxt;
  logic [SLOT_W-1:0] pid_nxt;
  logic              pcolor_nxt, found_nxt, armed_nxt, busy_nxt;
  logic [SQ_W-1:0]   msrc, msrc_nxt, mdst, mdst_nxt;
  logic              mvalid, mvalid_nxt;

  logic enter_rise_c, esc_rise_c, confirm_rise_c;

  btn_edge u_enter   (.clk(clk12), .rst_n(reset_n), .level(enter_pressed),   .rise_c(enter_rise_c));
  btn_edge u_esc     (.clk(clk12), .rst_n(reset_n), .level(esc_pressed),     .rise_c(esc_rise_c));
  btn_edge u_confirm (.clk(clk12), .rst_n(reset_n), .level(confirm_pressed), .rise_c(confirm_rise_c));

  // Slot under examination this cycle; idx[4] selects the black vectors.
  logic [SLOT_W-1:0] slot_c;
  logic              black_c;
  logic [6:0]        base_c;
  logic [SQ_W-1:0]   loc_c;
  logic              alive_c;
  logic              match_c;

  assign slot_c  = idx[SLOT_W-1:0];
  assign black_c = idx[IDX_W-1];
  assign base_c  = 7'(slot_c) * 7'(SQ_W);
  assign loc_c   = black_c ? lvb[base_c +: SQ_W] : lvw[base_c +: SQ_W];
  assign alive_c = black_c ? avb[slot_c] : avw[slot_c];

`ifdef TURN_CHECK_EN
  // Opponent pieces look like empty squares.
  assign match_c = alive_c && (loc_c == src) && ((~black_c) == player_in);
`else
  logic player_unused;
  assign player_unused = player_in;
  assign match_c = alive_c && (loc_c == src);
`endif

  // State and output registers.
  always_ff @(posedge clk12 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      src         <= '0;
      pid         <= '0;
      pcolor      <= 1'b0;
      found_piece <= 1'b0;
      dst_armed   <= 1'b0;
      busy        <= 1'b0;
      msrc        <= '0;
      mdst        <= '0;
      mvalid      <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      src         <= src_nxt;
      pid         <= pid_nxt;
      pcolor      <= pcolor_nxt;
      found_piece <= found_nxt;
      dst_armed   <= armed_nxt;
      busy        <= busy_nxt;
      msrc        <= msrc_nxt;
      mdst        <= mdst_nxt;
      mvalid      <= mvalid_nxt;
    end
  end

  // Next-state and next-output logic; esc takes priority over enter/confirm.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    src_nxt    = src;
    pid_nxt    = pid;
    pcolor_nxt = pcolor;
    found_nxt  = found_piece;
    armed_nxt  = dst_armed;
    msrc_nxt   = msrc;
    mdst_nxt   = mdst;
    mvalid_nxt = mvalid;

    case (state)
      IDLE: begin
        if (!esc_rise_c && enter_rise_c) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
          src_nxt   = cursor;
        end
      end
      SCAN: begin
        if (esc_rise_c) begin
          state_nxt = IDLE;
          found_nxt = 1'b0;
        end else if (match_c) begin
          state_nxt  = SELECTED;
          pid_nxt    = slot_c;
          pcolor_nxt = ~black_c;
          found_nxt  = 1'b1;
          msrc_nxt   = src;
        end else if (idx == IDX_W'(2 * NUM_SLOTS - 1)) begin
          state_nxt = IDLE;
          found_nxt = 1'b0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      SELECTED: begin
        if (esc_rise_c) begin
          state_nxt  = IDLE;
          found_nxt  = 1'b0;
          pid_nxt    = '0;
          pcolor_nxt = 1'b0;
        end else if (enter_rise_c && (cursor != msrc)) begin
          state_nxt = ARMED;
          mdst_nxt  = cursor;
          armed_nxt = 1'b1;
        end
      end
      ARMED: begin
        if (esc_rise_c) begin
          state_nxt = SELECTED;
          armed_nxt = 1'b0;
          mdst_nxt  = '0;
        end else if (confirm_rise_c) begin
          state_nxt  = MOVE_REQ;
          mvalid_nxt = 1'b1;
        end
      end
      MOVE_REQ: begin
        // Buttons are ignored until the engine takes the move.
        if (mv.move_ready) begin
          state_nxt  = IDLE;
          mvalid_nxt = 1'b0;
          found_nxt  = 1'b0;
          armed_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign mv.move_valid = mvalid;
  assign mv.move_src   = msrc;
  assign mv.move_dst   = mdst;

endmodule

// File: tb/tb_chess_select_ctrl.sv
// Directed bench for chess_select_ctrl: reset, scan timing, full move,
// escape paths, turn check and async abort.
module tb_chess_select_ctrl;
  import chess_pkg::*;

  logic              clk12 = 1'b0;
  logic              reset_n;
  logic [SQ_W-1:0]   cursor;
  logic              enter_pressed, esc_pressed, confirm_pressed;
  logic [LV_W-1:0]   lvw, lvb;
  logic [NUM_SLOTS-1:0] avw, avb;
  logic              player_in;
  logic [SLOT_W-1:0] pid;
  logic              pcolor, found_piece, dst_armed, busy;

  int errors = 0;
  int checks = 0;

  chess_select_ctrl_if mv();

  chess_select_ctrl dut (
    .clk12(clk12), .reset_n(reset_n), .cursor(cursor),
    .enter_pressed(enter_pressed), .esc_pressed(esc_pressed),
    .confirm_pressed(confirm_pressed),
    .lvw(lvw), .lvb(lvb), .avw(avw), .avb(avb), .player_in(player_in),
    .pid(pid), .pcolor(pcolor), .found_piece(found_piece),
    .dst_armed(dst_armed), .busy(busy), .mv(mv)
  );

  always #5 clk12 = ~clk12;

  localparam logic [SQ_W-1:0] SQ_KING = 6'b000_100;
  localparam logic [SQ_W-1:0] SQ_PAWN = 6'b110_000;
  localparam logic [SQ_W-1:0] SQ_DST  = 6'b010_100;
  localparam logic [SQ_W-1:0] SQ_EMPT = 6'b011_011;

  task automatic tick();
    @(posedge clk12);
    #1;
  endtask

  task automatic press(input int which);
    if (which == 0) enter_pressed = 1'b1;
    else if (which == 1) esc_pressed = 1'b1;
    else confirm_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0; esc_pressed = 1'b0; confirm_pressed = 1'b0;
    tick();
  endtask

  // Select the piece on sq; bounded wait for the scan to finish.
  task automatic select_at(input logic [SQ_W-1:0] sq);
    bit done = 1'b0;
    cursor = sq;
    enter_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0;
    for (int i = 0; i < 34 && !done; i++) begin
      tick();
      if (found_piece || !busy) done = 1'b1;
    end
    checks++;
    if (found_piece !== 1'b1) begin
      errors++;
      $display("FAIL select_at sq=%b found_piece=%b required 1", sq, found_piece);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cursor = '0; enter_pressed = 0; esc_pressed = 0; confirm_pressed = 0;
    mv.move_ready = 1'b0; player_in = 1'b1;
    lvw = '0; lvb = '0; avw = '0; avb = '0;
    lvw[0*SQ_W +: SQ_W] = SQ_KING; avw[0] = 1'b1;
    lvw[1*SQ_W +: SQ_W] = 6'b000_011; avw[1] = 1'b1;
    lvb[8*SQ_W +: SQ_W] = SQ_PAWN; avb[8] = 1'b1;
    lvb[0*SQ_W +: SQ_W] = 6'b111_100; avb[0] = 1'b1;
    lvw[9*SQ_W +: SQ_W] = SQ_EMPT; avw[9] = 1'b0;  // captured piece left on square
    repeat (3) tick();
    checks++;
    if ({pid, pcolor, found_piece, dst_armed, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_status got=%h required 00", {pid, pcolor, found_piece, dst_armed, busy});
    end
    checks++;
    if ({mv.move_valid, mv.move_src, mv.move_dst} !== 13'h0) begin
      errors++;
      $display("FAIL reset_move got=%h required 0", {mv.move_valid, mv.move_src, mv.move_dst});
    end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_scan_white_king();
    cursor = SQ_KING;
    enter_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0;
    checks++;
    if (busy !== 1'b1 || found_piece !== 1'b0) begin
      errors++;
      $display("FAIL king_E+1 busy=%b found=%b required busy=1 found=0", busy, found_piece);
    end
    tick();
    checks++;
    if ({found_piece, pid, pcolor, mv.move_src} !== {1'b1, 4'd0, 1'b1, SQ_KING}) begin
      errors++;
      $display("FAIL king_E+2 found=%b pid=%0d pcolor=%b src=%b required 1/0/1/%b",
               found_piece, pid, pcolor, mv.move_src, SQ_KING);
    end
    press(1);
    checks++;
    if ({found_piece, busy, pid, pcolor} !== 7'b0) begin
      errors++;
      $display("FAIL king_esc found=%b busy=%b pid=%0d pcolor=%b required all 0", found_piece, busy, pid, pcolor);
    end
  endtask

  task automatic test_scan_black_and_empty();
    cursor = SQ_PAWN;
    enter_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0;
    repeat (24) tick();
    checks++;
    if (found_piece !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pawn_E+25 found=%b busy=%b required 0/1", found_piece, busy);
    end
    tick();
    checks++;
    if ({found_piece, pid, pcolor} !== {1'b1, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL pawn_E+26 found=%b pid=%0d pcolor=%b required 1/8/0", found_piece, pid, pcolor);
    end
    press(1);
    cursor = SQ_EMPT;
    enter_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0;
    repeat (31) tick();
    checks++;
    if (busy !== 1'b1 || found_piece !== 1'b0) begin
      errors++;
      $display("FAIL empty_E+32 busy=%b found=%b required 1/0", busy, found_piece);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || found_piece !== 1'b0) begin
      errors++;
      $display("FAIL empty_E+33 busy=%b found=%b required 0/0", busy, found_piece);
    end
  endtask

  task automatic test_full_move();
    select_at(SQ_KING);
    press(0);  // cursor still on source: ignored
    checks++;
    if (dst_armed !== 1'b0) begin
      errors++;
      $display("FAIL same_square_enter dst_armed=%b required 0", dst_armed);
    end
    cursor = SQ_DST;
    press(0);
    checks++;
    if (dst_armed !== 1'b1 || mv.move_dst !== SQ_DST) begin
      errors++;
      $display("FAIL armed dst_armed=%b dst=%b required 1/%b", dst_armed, mv.move_dst, SQ_DST);
    end
    confirm_pressed = 1'b1;
    tick();
    confirm_pressed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mv.move_valid, mv.move_src, mv.move_dst, pid, busy} !== {1'b1, SQ_KING, SQ_DST, 4'd0, 1'b1}) begin
        errors++;
        $display("FAIL move_hold cyc=%0d valid=%b src=%b dst=%b pid=%0d busy=%b required 1/%b/%b/0/1",
                 i, mv.move_valid, mv.move_src, mv.move_dst, pid, busy, SQ_KING, SQ_DST);
      end
      esc_pressed = (i == 1);
      enter_pressed = (i == 3);
      tick();
    end
    esc_pressed = 1'b0; enter_pressed = 1'b0;
    mv.move_ready = 1'b1;
    tick();
    mv.move_ready = 1'b0;
    checks++;
    if ({mv.move_valid, found_piece, dst_armed, busy} !== 4'b0) begin
      errors++;
      $display("FAIL handshake valid=%b found=%b armed=%b busy=%b required all 0",
               mv.move_valid, found_piece, dst_armed, busy);
    end
    mv.move_ready = 1'b1;  // stray ready while idle
    tick();
    mv.move_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || mv.move_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_ready busy=%b valid=%b required 0/0", busy, mv.move_valid);
    end
  endtask

  task automatic test_escape();
    select_at(SQ_KING);
    cursor = SQ_DST;
    press(0);
    press(1);
    checks++;
    if ({dst_armed, mv.move_dst, found_piece, busy} !== {1'b0, 6'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL armed_esc armed=%b dst=%b found=%b busy=%b required 0/000000/1/1",
               dst_armed, mv.move_dst, found_piece, busy);
    end
    press(1);
    checks++;
    if ({found_piece, busy, pid} !== 6'b0) begin
      errors++;
      $display("FAIL selected_esc found=%b busy=%b pid=%0d required 0/0/0", found_piece, busy, pid);
    end
    select_at(6'b000_011);
    checks++;
    if (pid !== 4'd1) begin
      errors++;
      $display("FAIL queen_pid pid=%0d required 1", pid);
    end
    cursor = SQ_DST;
    enter_pressed = 1'b1; esc_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0; esc_pressed = 1'b0;
    tick();
    checks++;
    if ({busy, dst_armed, found_piece} !== 3'b0) begin
      errors++;
      $display("FAIL enter_esc_same busy=%b armed=%b found=%b required 0/0/0", busy, dst_armed, found_piece);
    end
  endtask

  task automatic test_turn_check();
    player_in = 1'b0;
    cursor = SQ_KING;
    enter_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0;
`ifdef TURN_CHECK_EN
    repeat (32) tick();
    checks++;
    if (found_piece !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL turn_check found=%b busy=%b required 0/0", found_piece, busy);
    end
`else
    tick();
    checks++;
    if (found_piece !== 1'b1 || pcolor !== 1'b1) begin
      errors++;
      $display("FAIL any_colour found=%b pcolor=%b required 1/1", found_piece, pcolor);
    end
    press(1);
`endif
    player_in = 1'b1;
    tick();
  endtask

  task automatic test_reset_abort();
    select_at(SQ_KING);
    cursor = SQ_DST;
    press(0);
    press(2);
    checks++;
    if (mv.move_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup valid=%b required 1", mv.move_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mv.move_valid, busy, found_piece, dst_armed} !== 4'b0) begin
      errors++;
      $display("FAIL async_abort valid=%b busy=%b found=%b armed=%b required all 0",
               mv.move_valid, busy, found_piece, dst_armed);
    end
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || mv.move_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset busy=%b valid=%b required 0/0", busy, mv.move_valid);
    end
    select_at(SQ_PAWN);
    checks++;
    if (pid !== 4'd8 || pcolor !== 1'b0) begin
      errors++;
      $display("FAIL reselect pid=%0d pcolor=%b required 8/0", pid, pcolor);
    end
  endtask

  initial begin
    test_reset();
    test_scan_white_king();
    test_scan_black_and_empty();
    test_full_move();
    test_escape();
    test_turn_check();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
